// File: rtl/instr_aligner.sv
// Instruction aligner: turns 32-bit prefetch words into one whole instruction per cycle.
// Define INSTR_ALIGN_COMPRESSED_EN to enable 16-bit instructions and the halfword hold buffer.
module instr_aligner #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pf_valid_i,
    input  logic [XLEN-1:0] pf_pc_i,
    input  logic [31:0]     pf_word_i,
    input  logic            pf_fault_i,
    output logic            pf_ready_o,
    input  logic            flush_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [31:0]     if_instr_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic            if_is_comp_o,
    output logic            if_fault_o
);

    logic            r_vld_p1;
    logic [31:0]     r_instr_p1;
    logic [XLEN-1:0] r_pc_p1;
    logic            r_comp_p1;
    logic            r_flt_p1;

    logic            w_adv;
    logic            w_take;
    logic            w_emit_p0;
    logic [31:0]     w_instr_p0;
    logic [XLEN-1:0] w_pc_p0;
    logic            w_comp_p0;
    logic            w_flt_p0;

    assign w_adv  = !r_vld_p1 || if_ready_i;
    assign w_take = w_adv && !flush_i;

`ifdef INSTR_ALIGN_COMPRESSED_EN
    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_hold;
    logic [15:0]     w_hold_nxt;
    logic [XLEN-1:0] r_hold_pc;
    logic [XLEN-1:0] w_hold_pc_nxt;
    logic            r_hold_flt;
    logic            w_hold_flt_nxt;

    function automatic logic is_comp(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

    // A held compressed half drains without consuming a new word.
    assign pf_ready_o = w_take && (r_state == EMPTY || r_hold[1:0] == 2'b11);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_hold     <= '0;
            r_hold_pc  <= '0;
            r_hold_flt <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_hold_pc  <= w_hold_pc_nxt;
            r_hold_flt <= w_hold_flt_nxt;
        end
    end

    // Stage p0: pick the instruction to emit and what half to keep.
    always_comb begin
        w_state_nxt    = flush_i ? EMPTY : r_state;
        w_hold_nxt     = r_hold;
        w_hold_pc_nxt  = r_hold_pc;
        w_hold_flt_nxt = r_hold_flt;
        w_emit_p0      = 1'b0;
        w_instr_p0     = pf_word_i;
        w_pc_p0        = pf_pc_i;
        w_comp_p0      = 1'b0;
        w_flt_p0       = pf_fault_i;
        if (w_take) begin
            case (r_state)
                EMPTY: begin
                    if (pf_valid_i) begin
                        if (pf_fault_i) begin
                            w_emit_p0 = 1'b1;
                        end else if (!pf_pc_i[1]) begin
                            w_emit_p0 = 1'b1;
                            if (is_comp(pf_word_i[15:0])) begin
                                w_instr_p0     = {16'h0000, pf_word_i[15:0]};
                                w_comp_p0      = 1'b1;
                                w_hold_nxt     = pf_word_i[31:16];
                                w_hold_pc_nxt  = pf_pc_i + XLEN'(2);
                                w_hold_flt_nxt = 1'b0;
                                w_state_nxt    = HALF;
                            end
                        end else if (is_comp(pf_word_i[31:16])) begin
                            w_emit_p0  = 1'b1;
                            w_instr_p0 = {16'h0000, pf_word_i[31:16]};
                            w_comp_p0  = 1'b1;
                        end else begin
                            w_hold_nxt     = pf_word_i[31:16];
                            w_hold_pc_nxt  = pf_pc_i;
                            w_hold_flt_nxt = 1'b0;
                            w_state_nxt    = HALF;
                        end
                    end
                end
                HALF: begin
                    if (is_comp(r_hold)) begin
                        w_emit_p0   = 1'b1;
                        w_instr_p0  = {16'h0000, r_hold};
                        w_pc_p0     = r_hold_pc;
                        w_comp_p0   = 1'b1;
                        w_flt_p0    = r_hold_flt;
                        w_state_nxt = EMPTY;
                    end else if (pf_valid_i) begin
                        // Word is sequential to the held half, so pf_pc_i is not consulted.
                        w_emit_p0  = 1'b1;
                        w_instr_p0 = {pf_word_i[15:0], r_hold};
                        w_pc_p0    = r_hold_pc;
                        w_flt_p0   = r_hold_flt || pf_fault_i;
                        if (pf_fault_i) begin
                            w_state_nxt = EMPTY;
                        end else begin
                            w_hold_nxt     = pf_word_i[31:16];
                            w_hold_pc_nxt  = r_hold_pc + XLEN'(4);
                            w_hold_flt_nxt = 1'b0;
                        end
                    end
                end
            endcase
        end
    end
`else
    // Stage p0: every word is one 32-bit instruction; a halfword PC is flagged as a fault.
    assign pf_ready_o = w_take;
    assign w_emit_p0  = w_take && pf_valid_i;
    assign w_instr_p0 = pf_word_i;
    assign w_pc_p0    = pf_pc_i;
    assign w_comp_p0  = 1'b0;
    assign w_flt_p0   = pf_fault_i || pf_pc_i[1];
`endif

    // Stage p1: registered output stream; data only moves when an instruction is emitted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1   <= 1'b0;
            r_instr_p1 <= '0;
            r_pc_p1    <= RESET_PC;
            r_comp_p1  <= 1'b0;
            r_flt_p1   <= 1'b0;
        end else if (flush_i) begin
            r_vld_p1 <= 1'b0;
        end else if (w_adv) begin
            r_vld_p1 <= w_emit_p0;
            if (w_emit_p0) begin
                r_instr_p1 <= w_instr_p0;
                r_pc_p1    <= w_pc_p0;
                r_comp_p1  <= w_comp_p0;
                r_flt_p1   <= w_flt_p0;
            end
        end
    end

    assign if_valid_o   = r_vld_p1;
    assign if_instr_o   = r_instr_p1;
    assign if_pc_o      = r_pc_p1;
    assign if_is_comp_o = r_comp_p1;
    assign if_fault_o   = r_flt_p1;

endmodule

// File: tb/tb_instr_aligner.sv
// Scoreboard bench for instr_aligner; follows the build's INSTR_ALIGN_COMPRESSED_EN setting.
`timescale 1ns/1ps
module tb_instr_aligner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pf_valid_i = 1'b0;
    logic [31:0] pf_pc_i = '0;
    logic [31:0] pf_word_i = '0;
    logic        pf_fault_i = 1'b0;
    logic        pf_ready_o;
    logic        flush_i = 1'b0;
    logic        if_valid_o;
    logic        if_ready_i = 1'b1;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        if_is_comp_o;
    logic        if_fault_o;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        comp;
        logic        flt;
    } exp_t;

    exp_t q_exp[$];
    exp_t mon_got;
    exp_t mon_want;
    int   n_tests = 0;
    int   n_fail  = 0;

    instr_aligner #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst(rst),
        .pf_valid_i(pf_valid_i), .pf_pc_i(pf_pc_i), .pf_word_i(pf_word_i),
        .pf_fault_i(pf_fault_i), .pf_ready_o(pf_ready_o), .flush_i(flush_i),
        .if_valid_o(if_valid_o), .if_ready_i(if_ready_i), .if_instr_o(if_instr_o),
        .if_pc_o(if_pc_o), .if_is_comp_o(if_is_comp_o), .if_fault_o(if_fault_o)
    );

    always #5 clk = ~clk;

    // Every completed handshake is matched against the oldest expected instruction.
    always @(negedge clk) begin
        if (!rst && if_valid_o && if_ready_i) begin
            mon_got = {if_instr_o, if_pc_o, if_is_comp_o, if_fault_o};
            n_tests++;
            if (q_exp.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: got instr=%h pc=%h comp=%b flt=%b, required no output",
                         mon_got.instr, mon_got.pc, mon_got.comp, mon_got.flt);
            end else begin
                mon_want = q_exp.pop_front();
                if (mon_got !== mon_want) begin
                    n_fail++;
                    $display("FAIL sb_instr: got instr=%h pc=%h comp=%b flt=%b, required instr=%h pc=%h comp=%b flt=%b",
                             mon_got.instr, mon_got.pc, mon_got.comp, mon_got.flt,
                             mon_want.instr, mon_want.pc, mon_want.comp, mon_want.flt);
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc,
                            input logic comp, input logic flt);
        exp_t e;
        e = {instr, pc, comp, flt};
        q_exp.push_back(e);
    endtask

    // Present a word and hold it until the aligner consumes it; returns cycles stalled.
    task automatic drive_word(input logic [31:0] pc, input logic [31:0] w,
                              input logic flt, output int waits);
        bit taken;
        pf_valid_i = 1'b1;
        pf_pc_i    = pc;
        pf_word_i  = w;
        pf_fault_i = flt;
        waits      = 0;
        taken      = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (pf_ready_o) begin
                taken = 1'b1;
                break;
            end
            waits++;
        end
        if (!taken) begin
            n_tests++;
            n_fail++;
            $display("FAIL drive_timeout: got pf_ready_o=0 for 100 cycles at pc=%h, required 1", pc);
        end
        @(posedge clk);
        #1;
        pf_valid_i = 1'b0;
        pf_fault_i = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (q_exp.size() == 0) break;
        end
        #1;
        n_tests++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d instructions still pending, required 0", name, q_exp.size());
        end
        q_exp.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (if_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", if_valid_o); end
        n_tests++; if (if_pc_o !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_pc: got %h, required 80000000", if_pc_o); end
        n_tests++; if (pf_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, required 1", pf_ready_o); end
        n_tests++; if (if_instr_o !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h, required 0", if_instr_o); end
        n_tests++; if (if_is_comp_o !== 1'b0) begin n_fail++; $display("FAIL rst_comp: got %b, required 0", if_is_comp_o); end
        n_tests++; if (if_fault_o !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b, required 0", if_fault_o); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_aligned();
        int w;
        push_exp(32'h0050_0093, 32'h8000_0000, 1'b0, 1'b0);
        drive_word(32'h8000_0000, 32'h0050_0093, 1'b0, w);
        @(negedge clk);
        n_tests++;
        if (if_valid_o !== 1'b1 || if_instr_o !== 32'h0050_0093) begin
            n_fail++;
            $display("FAIL aligned_latency: got valid=%b instr=%h, required valid=1 instr=00500093", if_valid_o, if_instr_o);
        end
        drain("aligned");
    endtask

    task automatic test_back_to_back();
        int w1, w2, w3;
        push_exp(32'h0010_0093, 32'h0000_9000, 1'b0, 1'b0);
        push_exp(32'h0020_0113, 32'h0000_9004, 1'b0, 1'b0);
        push_exp(32'h0030_0193, 32'h0000_9008, 1'b0, 1'b0);
        drive_word(32'h0000_9000, 32'h0010_0093, 1'b0, w1);
        drive_word(32'h0000_9004, 32'h0020_0113, 1'b0, w2);
        drive_word(32'h0000_9008, 32'h0030_0193, 1'b0, w3);
        n_tests++;
        if (w2 + w3 !== 0) begin
            n_fail++;
            $display("FAIL b2b_stalls: got %0d stall cycles, required 0", w2 + w3);
        end
        drain("b2b");
    endtask

    task automatic test_backpressure();
        int w;
        logic [31:0] first_instr;
        logic        first_comp;
`ifdef INSTR_ALIGN_COMPRESSED_EN
        first_instr = 32'h0000_4605;
        first_comp  = 1'b1;
        push_exp(32'h0000_4605, 32'h0000_4000, 1'b1, 1'b0);
        push_exp(32'h0000_4609, 32'h0000_4002, 1'b1, 1'b0);
`else
        first_instr = 32'h4609_4605;
        first_comp  = 1'b0;
        push_exp(32'h4609_4605, 32'h0000_4000, 1'b0, 1'b0);
`endif
        push_exp(32'h00b0_0193, 32'h0000_4004, 1'b0, 1'b0);
        if_ready_i = 1'b0;
        drive_word(32'h0000_4000, 32'h4609_4605, 1'b0, w);
        pf_valid_i = 1'b1;
        pf_pc_i    = 32'h0000_4004;
        pf_word_i  = 32'h00b0_0193;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (if_valid_o !== 1'b1 || if_instr_o !== first_instr || if_pc_o !== 32'h0000_4000 ||
                if_is_comp_o !== first_comp) begin
                n_fail++;
                $display("FAIL bp_hold: got valid=%b instr=%h pc=%h comp=%b, required valid=1 instr=%h pc=00004000 comp=%b",
                         if_valid_o, if_instr_o, if_pc_o, if_is_comp_o, first_instr, first_comp);
            end
            n_tests++;
            if (pf_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_ready: got %b, required 0", pf_ready_o);
            end
        end
        @(posedge clk);
        #1;
        if_ready_i = 1'b1;
        drive_word(32'h0000_4004, 32'h00b0_0193, 1'b0, w);
        drain("bp");
    endtask

    task automatic test_flush_output();
        int w;
        if_ready_i = 1'b0;
        drive_word(32'h0000_5000, 32'h0000_0013, 1'b0, w);
        @(negedge clk);
        n_tests++;
        if (if_valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid: got %b, required 1", if_valid_o); end
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        n_tests++;
        if (pf_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b, required 0", pf_ready_o); end
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        n_tests++;
        if (if_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b, required 0", if_valid_o); end
        @(posedge clk);
        #1;
        if_ready_i = 1'b1;
    endtask

    task automatic test_fault();
        int w;
        push_exp(32'h4505_4501, 32'h0000_6000, 1'b0, 1'b1);
        push_exp(32'h00c0_0213, 32'h0000_6004, 1'b0, 1'b0);
        drive_word(32'h0000_6000, 32'h4505_4501, 1'b1, w);
        drive_word(32'h0000_6004, 32'h00c0_0213, 1'b0, w);
        drain("fault");
    endtask

`ifdef INSTR_ALIGN_COMPRESSED_EN
    task automatic test_double_comp();
        int w;
        push_exp(32'h0000_4501, 32'h0000_1000, 1'b1, 1'b0);
        push_exp(32'h0000_4505, 32'h0000_1002, 1'b1, 1'b0);
        drive_word(32'h0000_1000, 32'h4505_4501, 1'b0, w);
        @(negedge clk);
        n_tests++; if (if_valid_o !== 1'b1) begin n_fail++; $display("FAIL dbl_valid: got %b, required 1", if_valid_o); end
        n_tests++; if (if_is_comp_o !== 1'b1) begin n_fail++; $display("FAIL dbl_comp: got %b, required 1", if_is_comp_o); end
        n_tests++; if (pf_ready_o !== 1'b0) begin n_fail++; $display("FAIL dbl_ready: got %b, required 0", pf_ready_o); end
        @(negedge clk);
        n_tests++; if (if_pc_o !== 32'h0000_1002) begin n_fail++; $display("FAIL dbl_pc2: got %h, required 00001002", if_pc_o); end
        drain("dbl");
    endtask

    task automatic test_straddle();
        int w;
        push_exp(32'h0000_4501, 32'h0000_2000, 1'b1, 1'b0);
        push_exp(32'h0050_0093, 32'h0000_2002, 1'b0, 1'b0);
        push_exp(32'h0000_1234, 32'h0000_2006, 1'b1, 1'b0);
        drive_word(32'h0000_2000, 32'h0093_4501, 1'b0, w);
        drive_word(32'h0000_2004, 32'h1234_0050, 1'b0, w);
        drain("straddle");
    endtask

    task automatic test_flush_split();
        int w;
        drive_word(32'h0000_5002, 32'h0093_0000, 1'b0, w);
        @(negedge clk);
        n_tests++;
        if (if_valid_o !== 1'b0) begin n_fail++; $display("FAIL split_bubble: got %b, required 0", if_valid_o); end
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        n_tests++;
        if (pf_ready_o !== 1'b0) begin n_fail++; $display("FAIL split_flush_ready: got %b, required 0", pf_ready_o); end
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        n_tests++;
        if (if_valid_o !== 1'b0) begin n_fail++; $display("FAIL split_flush_valid: got %b, required 0", if_valid_o); end
        @(posedge clk);
        #1;
        push_exp(32'h0000_4585, 32'h0000_3002, 1'b1, 1'b0);
        drive_word(32'h0000_3002, 32'h4585_0000, 1'b0, w);
        drain("split_flush");
    endtask

    task automatic test_reset_midsplit();
        int w;
        drive_word(32'h0000_7002, 32'h0093_0000, 1'b0, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp(32'h00a0_0113, 32'h0000_7100, 1'b0, 1'b0);
        drive_word(32'h0000_7100, 32'h00a0_0113, 1'b0, w);
        drain("rst_split");
    endtask

    task automatic test_wrap();
        int w;
        push_exp(32'h0050_0093, 32'hFFFF_FFFE, 1'b0, 1'b0);
        push_exp(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0);
        drive_word(32'hFFFF_FFFE, 32'h0093_0000, 1'b0, w);
        drive_word(32'h0000_0000, 32'h0001_0050, 1'b0, w);
        drain("wrap");
    endtask
`else
    task automatic test_misaligned();
        int w;
        push_exp(32'h1234_5678, 32'h0000_6102, 1'b0, 1'b1);
        push_exp(32'h0050_0093, 32'h0000_6104, 1'b0, 1'b0);
        drive_word(32'h0000_6102, 32'h1234_5678, 1'b0, w);
        drive_word(32'h0000_6104, 32'h0050_0093, 1'b0, w);
        drain("misaligned");
    endtask
`endif

    initial begin
        test_reset();
        test_aligned();
        test_back_to_back();
        test_backpressure();
        test_flush_output();
        test_fault();
`ifdef INSTR_ALIGN_COMPRESSED_EN
        test_double_comp();
        test_straddle();
        test_flush_split();
        test_reset_midsplit();
        test_wrap();
`else
        test_misaligned();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_aligner.md
# instr_aligner

Instruction aligner between the prefetch stage and the fetch/decode stage. It accepts 32-bit words from prefetch and emits one whole instruction per cycle. 16-bit compressed instructions and 32-bit instructions that straddle a word boundary are handled with a one-halfword holding buffer. The output is a registered valid/ready stream, so prefetch and fetch are decoupled by one pipeline register.

## Interface
Parameters:
- `XLEN`, 32, instruction/PC width.
- `RESET_PC`, 32'h8000_0000, value driven on `if_pc_o` while idle after reset.

Ports:
- `clk` in 1: core clock.
- `rst` in 1: reset, synchronous, active-high.
- `pf_valid_i` in 1: prefetch word valid.
- `pf_pc_i` in XLEN: halfword-aligned PC of the first instruction wanted in the word. Bit 1 selects the starting half.
- `pf_word_i` in 32: fetched word, little-endian, word-aligned.
- `pf_fault_i` in 1: page/access fault on this word.
- `pf_ready_o` out 1: aligner consumes the word this cycle.
- `flush_i` in 1: redirect; drops all held and output state.
- `if_valid_o` out 1: instruction valid.
- `if_ready_i` in 1: fetch accepts the instruction.
- `if_instr_o` out 32: instruction; compressed instructions are zero-extended in bits [31:16].
- `if_pc_o` out XLEN: instruction PC.
- `if_is_comp_o` out 1: instruction is 16-bit.
- `if_fault_o` out 1: fault attached to the instruction.

## Operation
- Compressed test: `h[1:0] != 2'b11`.
- `adv = !if_valid_o || if_ready_i`. The output register loads only when `adv=1` and `flush_i=0`.
- State `EMPTY` (no held half) and state `HALF` (held `hold_q[15:0]`, `hold_pc_q`, `hold_flt_q`).
- Behaviour in `EMPTY` with `pf_valid_i=1`; the word is always consumed:
  - `pc[1]=0` and the low half is compressed: emit the low half at `pc`. Hold `w[31:16]` at `pc+2`. Go to `HALF`.
  - `pc[1]=0` and the low half is not compressed: emit `w` at `pc`. Stay in `EMPTY`.
  - `pc[1]=1` and the high half is compressed: emit the high half at `pc`. Stay in `EMPTY`.
  - `pc[1]=1` and the high half is not compressed: hold the high half at `pc`. Emit nothing. Go to `HALF`.
- Behaviour in `HALF` when the held half is compressed:
  - Emit it without consuming a word (`pf_ready_o=0`). Go to `EMPTY`.
- Behaviour in `HALF` when the held half is the low part of a 32-bit instruction:
  - Wait for `pf_valid_i`.
  - Emit `{w[15:0], hold_q}` at `hold_pc_q`, with `fault = hold_flt_q | pf_fault_i`.
  - Hold `w[31:16]` at `hold_pc_q+4`. Stay in `HALF`.
  - `pf_pc_i` is ignored in this case; prefetch guarantees the word is sequential.
- `pf_ready_o = adv & !flush_i & (state==EMPTY | hold_q[1:0]==2'b11)`. It is combinational and independent of `pf_valid_i`.
- Faults:
  - A faulting word is never split.
  - When `pf_fault_i=1` in `EMPTY`, emit one instruction at `pc` with `if_fault_o=1` and `if_is_comp_o=0`, and go to `EMPTY`.
- Flush:
  - `flush_i=1` sets state to `EMPTY` and clears `if_valid_o` on the next edge.
  - `pf_ready_o=0` during the flush cycle.
  - Flush has priority over every other event in the same cycle.
- PC arithmetic is modulo 2^XLEN; wrap-around from `32'hFFFF_FFFE` to `0` is legal.

## Timing
- Reset (`rst=1` at an edge) clears all outputs: `if_valid_o=0`, `if_instr_o=0`, `if_is_comp_o=0`, `if_fault_o=0`, `if_pc_o=RESET_PC`. State becomes `EMPTY` and the hold registers are cleared. `pf_ready_o` is 1 after reset, because `if_valid_o=0`.
- Reset mid-split discards the held half.
- Latency: 1 cycle from word acceptance to `if_valid_o`.
- Throughput: 1 instruction per cycle with `if_ready_i=1`. A word holding two compressed instructions takes 2 cycles, and `pf_ready_o` is low in the second cycle.
- Backpressure: while `if_valid_o & !if_ready_i`, all `if_*` outputs hold stable and `pf_ready_o=0`.
- A word that starts a split at `pc[1]=1` produces no output in its acceptance cycle (one bubble).

## Configuration
- `INSTR_ALIGN_COMPRESSED_EN` defined:
  - Full behaviour as above.
- `INSTR_ALIGN_COMPRESSED_EN` undefined:
  - The `HALF` state and hold registers are removed.
  - Every word is emitted as a 32-bit instruction at `pc`.
  - `if_is_comp_o` is tied to 0.
  - `pf_ready_o = adv & !flush_i`.
  - `pc[1]=1` is a protocol violation; the word is emitted with `if_fault_o=1`.

## Test plan
- Reset: hold `rst=1` for 2 cycles -> `if_valid_o=0`, `if_pc_o=32'h8000_0000`, `pf_ready_o=1`.
- Aligned 32-bit: word `32'h0050_0093` at `32'h8000_0000` -> next cycle `if_instr_o=32'h0050_0093`, `if_pc_o=32'h8000_0000`, `if_is_comp_o=0`.
- Double compressed: word `32'h4505_4501` at `32'h1000` -> expected:
  - cycle+1: `32'h0000_4501` @`32'h1000`, `if_is_comp_o=1`, `pf_ready_o=0`.
  - cycle+2: `32'h0000_4505` @`32'h1002`.
- Straddle: words `32'h0093_4501` @`32'h2000`, then `32'h1234_0050` @`32'h2004` -> expected outputs in order:
  - `32'h4501` @`32'h2000`.
  - `32'h0050_0093` @`32'h2002`.
  - `32'h1234` (compressed) @`32'h2006`.
- Backpressure: `if_ready_i=0` for 3 cycles with a valid output -> outputs unchanged and `pf_ready_o=0` throughout; release -> the stream resumes with no loss or duplication.
- Flush mid-split: hold the low half of a 32-bit instruction, then assert `flush_i=1` -> `if_valid_o=0` next cycle. Then send word `32'h4585_0000` @`32'h3002` -> output `32'h4585` @`32'h3002`, `if_is_comp_o=1`.
